// File: rtl/instr_fetch_stage_if.sv
// Fetch-stage bus: branch redirect, hazard stall, instruction memory
// and IF/ID outputs. master = fetch stage, slave = surrounding datapath.
interface instr_fetch_stage_if;
   logic        stall;
   logic        br_taken;
   logic [15:0] br_pc;
   logic [15:0] br_offset;
   logic [15:0] imem_data;
   logic [15:0] imem_addr;
   logic [15:0] pc;
   logic [15:0] id_instr;
   logic [15:0] id_pc;
   logic [3:0]  id_imm4;
   logic        id_valid;

   modport master (
      input  stall, br_taken, br_pc, br_offset, imem_data,
      output imem_addr, pc, id_instr, id_pc, id_imm4, id_valid
   );

   modport slave (
      output stall, br_taken, br_pc, br_offset, imem_data,
      input  imem_addr, pc, id_instr, id_pc, id_imm4, id_valid
   );
endinterface

// File: rtl/instr_fetch_stage.sv
// Fetch stage: PC, IF/ID register, branch redirect with one-bubble flush.
// Ports: clk, reset (async, active-high), bus (instr_fetch_stage_if.master).
module instr_fetch_stage #(
   parameter logic [15:0] RESET_PC  = 16'h0000,
   parameter logic [15:0] NOP_INSTR = 16'h0000,
   parameter logic [15:0] PC_STEP   = 16'h0001
) (
   input logic                  clk,
   input logic                  reset,
   instr_fetch_stage_if.master  bus
);

   logic [15:0] pc_q;
   logic [15:0] instr_q;
   logic [15:0] id_pc_q;
   logic        valid_q;
   logic [15:0] target;

   // Branch target relative to the word after the branch.
   assign target = bus.br_pc + PC_STEP + bus.br_offset;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         id_pc_q <= 16'h0000;
         valid_q <= 1'b0;
      end else begin
         // Redirect outranks stall, so both may be high together.
         priority case (1'b1)
            bus.br_taken: begin
               pc_q    <= target;
               instr_q <= NOP_INSTR;
               id_pc_q <= 16'h0000;
               valid_q <= 1'b0;
            end
            bus.stall: begin
               pc_q    <= pc_q;
               instr_q <= instr_q;
               id_pc_q <= id_pc_q;
               valid_q <= valid_q;
            end
            default: begin
               pc_q    <= pc_q + PC_STEP;
               instr_q <= bus.imem_data;
               id_pc_q <= pc_q;
               valid_q <= 1'b1;
            end
         endcase
      end
   end

   assign bus.imem_addr = pc_q;
   assign bus.pc        = pc_q;
   assign bus.id_instr  = instr_q;
   assign bus.id_pc     = id_pc_q;
   assign bus.id_imm4   = instr_q[3:0];
   assign bus.id_valid  = valid_q;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed vector bench for instr_fetch_stage.
// Table of single-edge vectors plus a hand-written async reset sequence.
module tb_instr_fetch_stage;

   typedef struct {
      logic        stall;
      logic        br_taken;
      logic [15:0] br_pc;
      logic [15:0] br_offset;
      logic [15:0] exp_pc;
      logic [15:0] exp_instr;
      logic [15:0] exp_id_pc;
      logic        exp_valid;
   } vec_t;

   logic clk;
   logic reset;
   int   checks;
   int   failures;

   logic [15:0] imem [64];
   vec_t        vecs [16];

   instr_fetch_stage_if bus ();

   instr_fetch_stage dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   assign bus.imem_data = imem[bus.imem_addr[5:0]];

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #50000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   task automatic chk(input string name,
                      input logic [15:0] act,
                      input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h expected=%h t=%0t",
                  name, act, exp, $time);
      end
   endtask

   task automatic chk_all(input string tag,
                          input logic [15:0] epc,
                          input logic [15:0] ein,
                          input logic [15:0] eid,
                          input logic        ev);
      chk({tag, ".pc"}, bus.pc, epc);
      chk({tag, ".imem_addr"}, bus.imem_addr, epc);
      chk({tag, ".id_instr"}, bus.id_instr, ein);
      chk({tag, ".id_pc"}, bus.id_pc, eid);
      chk({tag, ".id_imm4"}, {12'h0, bus.id_imm4}, {12'h0, ein[3:0]});
      chk({tag, ".id_valid"}, {15'h0, bus.id_valid}, {15'h0, ev});
   endtask

   task automatic run_vec(input int i);
      bus.stall     = vecs[i].stall;
      bus.br_taken  = vecs[i].br_taken;
      bus.br_pc     = vecs[i].br_pc;
      bus.br_offset = vecs[i].br_offset;
      @(posedge clk);
      #2;
      chk_all($sformatf("v%0d", i), vecs[i].exp_pc, vecs[i].exp_instr,
              vecs[i].exp_id_pc, vecs[i].exp_valid);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      for (int i = 0; i < 64; i++) imem[i] = 16'hA000 | 16'(i);
      imem[0] = 16'h1234;
      imem[1] = 16'h5679;
      imem[2] = 16'h9ABD;

      // stall, br, br_pc, br_off, pc, instr, id_pc, valid
      vecs[0]  = '{0, 0, 16'h0, 16'h0, 16'h0001, 16'h1234, 16'h0000, 1};
      vecs[1]  = '{0, 0, 16'h0, 16'h0, 16'h0002, 16'h5679, 16'h0001, 1};
      vecs[2]  = '{1, 0, 16'h0, 16'h0, 16'h0002, 16'h5679, 16'h0001, 1};
      vecs[3]  = '{1, 0, 16'h0, 16'h0, 16'h0002, 16'h5679, 16'h0001, 1};
      vecs[4]  = '{1, 0, 16'h0, 16'h0, 16'h0002, 16'h5679, 16'h0001, 1};
      vecs[5]  = '{0, 0, 16'h0, 16'h0, 16'h0003, 16'h9ABD, 16'h0002, 1};
      vecs[6]  = '{0, 1, 16'h0005, 16'hFFF9,
                   16'hFFFF, 16'h0000, 16'h0000, 0};
      vecs[7]  = '{0, 0, 16'h0, 16'h0, 16'h0000, 16'hA03F, 16'hFFFF, 1};
      vecs[8]  = '{0, 0, 16'h0, 16'h0, 16'h0001, 16'h1234, 16'h0000, 1};
      vecs[9]  = '{1, 1, 16'h0003, 16'h0003,
                   16'h0007, 16'h0000, 16'h0000, 0};
      vecs[10] = '{1, 0, 16'h0, 16'h0, 16'h0007, 16'h0000, 16'h0000, 0};
      vecs[11] = '{0, 0, 16'h0, 16'h0, 16'h0008, 16'hA007, 16'h0007, 1};
      vecs[12] = '{0, 0, 16'h0, 16'h0, 16'h0009, 16'hA008, 16'h0008, 1};
      vecs[13] = '{0, 1, 16'h000F, 16'h0000,
                   16'h0010, 16'h0000, 16'h0000, 0};
      vecs[14] = '{0, 1, 16'h001F, 16'h0000,
                   16'h0020, 16'h0000, 16'h0000, 0};
      vecs[15] = '{0, 0, 16'h0, 16'h0, 16'h0021, 16'hA020, 16'h0020, 1};

      bus.stall     = 1'b0;
      bus.br_taken  = 1'b0;
      bus.br_pc     = 16'h0;
      bus.br_offset = 16'h0;
      reset         = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk_all("reset", 16'h0000, 16'h0000, 16'h0000, 1'b0);

      for (int i = 0; i <= 12; i++) run_vec(i);

      // Async reset mid-cycle, with stall and branch also pending.
      #1;
      bus.stall    = 1'b1;
      bus.br_taken = 1'b1;
      bus.br_pc    = 16'h0040;
      reset        = 1'b1;
      #1;
      chk_all("async_rst", 16'h0000, 16'h0000, 16'h0000, 1'b0);
      @(posedge clk);
      #2;
      chk_all("rst_hold", 16'h0000, 16'h0000, 16'h0000, 1'b0);
      @(negedge clk);
      reset        = 1'b0;
      bus.stall    = 1'b0;
      bus.br_taken = 1'b0;
      bus.br_pc    = 16'h0;
      #1;
      chk_all("rst_rel", 16'h0000, 16'h0000, 16'h0000, 1'b0);

      for (int i = 13; i <= 15; i++) run_vec(i);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
